aes_host_link: RTL and testbench
================================

// Module: aes_host_link
// PURPOSE
//  Host-side end of the AES128 UART link; the initiator for the AES128 device.
//  Takes a 128-bit plaintext and a 128-bit key, and serialises them as a 32-byte
//  request frame into a UART transmitter. It then collects the 16-byte ciphertext
//  reply from a UART receiver and presents it as one 128-bit word.
//  Used on the bench/host FPGA to drive the device and for loopback tests.
// PARAMETERS
//  TX_BYTES    32         request frame length: 16 plaintext bytes, then 16 key bytes
//  RX_BYTES    16         reply frame length (ciphertext)
//  TIMEOUT     2_000_000  idle clk cycles allowed between reply bytes before abort
//  TMR_W       21         timeout counter width; must satisfy 2**TMR_W > TIMEOUT
// PORTS
//  clk            in   1    system clock
//  rst_n          in   1    asynchronous active-low reset
//  start_in       in   1    1-cycle request; sampled only in IDLE
//  plaintext_in   in   128  plaintext; captured on accepted start
//  key_in         in   128  key; captured on accepted start
//  busy_out       out  1    high from the cycle after accepted start until DONE/abort
//  result_out     out  128  last complete ciphertext; holds value between frames
//  done_out       out  1    1-cycle pulse: result_out updated this cycle
//  timeout_out    out  1    1-cycle pulse: reply aborted; result_out unchanged
//  tx_dv_out      out  1    1-cycle byte strobe to transmitter (Tx_DV_in)
//  tx_byte_out    out  8    byte to transmitter, valid while tx_dv_out is high
//  tx_active_in   in   1    transmitter busy (Tx_Active_out)
//  tx_done_in     in   1    transmitter byte-complete pulse (Tx_Done_out)
//  rx_dv_in       in   1    receiver byte-valid pulse (Rx_DV_out)
//  rx_byte_in     in   8    receiver byte (Rx_Byte_out)
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE; takes effect immediately (async).
//  Byte order: MSB first. Request byte i is bits [127-8i -: 8] of the plaintext
//   for i<16, and of the key for i>=16. Reply byte j fills bits [127-8j -: 8].
//  FSM:
//   IDLE --start_in--> SEND. Inputs are latched into a 256-bit shift register,
//    and tx_cnt and rx_cnt are cleared.
//   SEND: wait for tx_active_in==0, then assert tx_dv_out for exactly 1 cycle
//    with the current MSB byte, then go to WAIT_TX.
//   WAIT_TX: on tx_done_in, shift by 8 and tx_cnt++.
//    If tx_cnt reaches TX_BYTES, go to RECV and load the timer; else go to SEND.
//   RECV: on rx_dv_in, shift rx_byte_in into the LSB of the 128-bit reply
//    register, rx_cnt++, and reload the timer.
//    When rx_cnt reaches RX_BYTES, go to DONE.
//    If the timer reaches 0, pulse timeout_out and go to IDLE.
//   DONE: copy reply register to result_out, pulse done_out, go to IDLE
//    (1 cycle).
//  Latency: done_out rises 1 clk after the cycle that delivers the 16th rx_dv_in.
//  Boundaries:
//   - start_in outside IDLE is ignored; the latched operands are never modified.
//   - rx_dv_in outside RECV is discarded; it flushes stale/echo bytes.
//   - rx_dv_in in the same cycle as timer expiry: the byte is taken and the
//     timer reloads, so no timeout occurs.
//   - tx_done_in outside WAIT_TX is ignored.
//   - start_in in the same cycle as done_out or timeout_out is ignored
//     (state is not yet IDLE).
//   - Counters are exact; no wrap-around. tx_cnt is 6 bits, rx_cnt is 5 bits.
//   - Reset mid-frame: tx_dv_out drops at once; the partial reply is lost and
//     result_out is cleared.
// STRUCTURE
//  Package aes_link_pkg: FSM state encoding (IDLE, SEND, WAIT_TX, RECV, DONE),
//   plus TX_BYTES, RX_BYTES and the default TIMEOUT constants.
//  Sub-module link_timer (load, tick, expired): down-counter of width TMR_W.
//  Everything else (FSM, shift registers, counters) lives in aes_host_link.
// TESTING
//  T1 FIPS-197 vector: pt=00112233445566778899aabbccddeeff,
//     key=000102030405060708090a0b0c0d0e0f. Expect tx byte sequence 00,11,..ff,00,01,..0f.
//     Reply 69c4e0d86a7b0430d8cdb78070b4c55a -> result_out equal, one done_out pulse.
//  T2 Send 10 of 16 reply bytes, then stay silent -> timeout_out after TIMEOUT cycles.
//     result_out keeps its T1 value; busy_out low.
//  T3 Pulse start_in during SEND and during RECV -> no effect.
//     Frame completes with the original operands.
//  T4 Hold tx_active_in high for 500 cycles before byte 5 -> tx_dv_out held low.
//     Exactly 32 tx_dv_out pulses in total.
//  T5 Inject rx_dv_in with byte AA during SEND -> discarded; the T1 reply still matches.
//  T6 Assert rst_n=0 after byte 20 of the request -> all outputs 0 immediately.
//     A new start afterwards completes T1 correctly.

Source files
------------

// File: rtl/aes_link_pkg.sv
// Shared definitions for the AES128 UART host link: FSM encoding and frame constants.
package aes_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    RECV,
    DONE
  } link_state_e;

  localparam int TX_BYTES = 32;
  localparam int RX_BYTES = 16;
  localparam int TIMEOUT  = 2_000_000;

endpackage

// File: rtl/link_timer.sv
// Reply inactivity timer: a loadable down-counter that stops at zero and flags expiry.
module link_timer #(
  parameter int TMR_W    = 21,
  parameter int LOAD_VAL = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic expired
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TMR_W'(LOAD_VAL);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/aes_host_link.sv
// Host side of the AES128 UART link: sends plaintext+key as a 32-byte request
// and assembles the 16-byte ciphertext reply into one 128-bit result.
module aes_host_link #(
  parameter int TX_BYTES = aes_link_pkg::TX_BYTES,
  parameter int RX_BYTES = aes_link_pkg::RX_BYTES,
  parameter int TIMEOUT  = aes_link_pkg::TIMEOUT,
  parameter int TMR_W    = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_in,
  input  logic [127:0] plaintext_in,
  input  logic [127:0] key_in,
  output logic         busy_out,
  output logic [127:0] result_out,
  output logic         done_out,
  output logic         timeout_out,
  output logic         tx_dv_out,
  output logic [7:0]   tx_byte_out,
  input  logic         tx_active_in,
  input  logic         tx_done_in,
  input  logic         rx_dv_in,
  input  logic [7:0]   rx_byte_in
);

  import aes_link_pkg::*;

  localparam logic [5:0] TX_LAST = 6'(TX_BYTES - 1);
  localparam logic [4:0] RX_LAST = 5'(RX_BYTES - 1);

  link_state_e  state;
  logic [255:0] req_sh;
  logic [119:0] reply;
  logic [5:0]   tx_cnt;
  logic [4:0]   rx_cnt;
  logic         tmr_load;
  logic         tmr_tick;
  logic         tmr_expired;

  // Timer restarts when the reply phase opens and on every accepted reply byte.
  assign tmr_load = ((state == WAIT_TX) && tx_done_in && (tx_cnt == TX_LAST)) ||
                    ((state == RECV) && rx_dv_in);
  assign tmr_tick = (state == RECV);

  link_timer #(
    .TMR_W   (TMR_W),
    .LOAD_VAL(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .tick   (tmr_tick),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      busy_out    <= 1'b0;
      result_out  <= '0;
      done_out    <= 1'b0;
      timeout_out <= 1'b0;
      tx_dv_out   <= 1'b0;
      tx_byte_out <= '0;
    end else begin
      tx_dv_out   <= 1'b0;
      tx_byte_out <= '0;
      done_out    <= 1'b0;
      timeout_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state    <= SEND;
            busy_out <= 1'b1;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
          end
        end
        SEND: begin
          if (!tx_active_in) begin
            tx_dv_out   <= 1'b1;
            tx_byte_out <= req_sh[255:248];
            state       <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_done_in) begin
            tx_cnt <= tx_cnt + 6'd1;
            state  <= (tx_cnt == TX_LAST) ? RECV : SEND;
          end
        end
        // The last reply byte goes straight into result_out so done_out follows it by one clock.
        RECV: begin
          if (rx_dv_in) begin
            rx_cnt <= rx_cnt + 5'd1;
            if (rx_cnt == RX_LAST) begin
              result_out <= {reply, rx_byte_in};
              done_out   <= 1'b1;
              busy_out   <= 1'b0;
              state      <= DONE;
            end
          end else if (tmr_expired) begin
            timeout_out <= 1'b1;
            busy_out    <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Frame data paths carry no reset; the FSM decides when their contents matter.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start_in) begin
      req_sh <= {plaintext_in, key_in};
    end else if ((state == WAIT_TX) && tx_done_in) begin
      req_sh <= {req_sh[247:0], 8'h00};
    end
    if ((state == RECV) && rx_dv_in) begin
      reply <= {reply[111:0], rx_byte_in};
    end
  end

endmodule

// File: tb/tb_aes_host_link.sv
// Scoreboard bench for aes_host_link with a behavioural UART transmitter responder.
module tb_aes_host_link;

  localparam int TMO = 300;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_in = 1'b0;
  logic [127:0] plaintext_in = '0;
  logic [127:0] key_in = '0;
  logic         busy_out;
  logic [127:0] result_out;
  logic         done_out;
  logic         timeout_out;
  logic         tx_dv_out;
  logic [7:0]   tx_byte_out;
  logic         tx_active_in;
  logic         tx_done_in = 1'b0;
  logic         rx_dv_in = 1'b0;
  logic [7:0]   rx_byte_in = '0;

  logic uart_busy = 1'b0;
  logic hold_active = 1'b0;
  assign tx_active_in = uart_busy | hold_active;

  aes_host_link #(
    .TIMEOUT(TMO),
    .TMR_W  (9)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_in    (start_in),
    .plaintext_in(plaintext_in),
    .key_in      (key_in),
    .busy_out    (busy_out),
    .result_out  (result_out),
    .done_out    (done_out),
    .timeout_out (timeout_out),
    .tx_dv_out   (tx_dv_out),
    .tx_byte_out (tx_byte_out),
    .tx_active_in(tx_active_in),
    .tx_done_in  (tx_done_in),
    .rx_dv_in    (rx_dv_in),
    .rx_byte_in  (rx_byte_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_tmo;
    logic [127:0] val;
  } ev_t;

  ev_t        exp_ev[$];
  logic [7:0] exp_tx[$];
  int         tx_pulses = 0;
  int         last_rx_cyc = 0;
  int         checks = 0;
  int         errors = 0;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input bit ok, input int info);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: value %0d (t=%0t)", name, info, $time);
    end
  endtask

  // Transmitter model: busy for 4 cycles per byte, then a one-cycle done pulse.
  initial forever begin
    @(negedge clk);
    if (tx_dv_out) begin
      uart_busy = 1'b1;
      repeat (4) @(negedge clk);
      tx_done_in = 1'b1;
      uart_busy  = 1'b0;
      @(negedge clk);
      tx_done_in = 1'b0;
    end
  end

  // Request-byte monitor.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_dv_out) begin
      tx_pulses++;
      if (exp_tx.size() == 0) begin
        flag("tx_unexpected_byte", 1'b0, int'(tx_byte_out));
      end else begin
        check("tx_byte", {120'h0, tx_byte_out}, {120'h0, exp_tx.pop_front()});
      end
    end
  end

  // Completion monitor for done_out / timeout_out.
  initial forever begin
    ev_t ev;
    int  dly;
    @(negedge clk);
    if (rst_n && (done_out || timeout_out)) begin
      if (exp_ev.size() == 0) begin
        flag("unexpected_completion", 1'b0, {30'h0, done_out, timeout_out});
      end else begin
        ev = exp_ev.pop_front();
        check("ev_timeout_flag", {127'h0, timeout_out}, {127'h0, ev.is_tmo});
        check("ev_done_flag", {127'h0, done_out}, {127'h0, !ev.is_tmo});
        if (ev.is_tmo) begin
          dly = cyc - last_rx_cyc;
          flag("timeout_delay", (dly >= TMO + 1) && (dly <= TMO + 3), dly);
        end else begin
          check("result", result_out, ev.val);
        end
      end
    end
  end

  task automatic push_tx(input logic [127:0] pt, input logic [127:0] key);
    logic [255:0] f;
    f = {pt, key};
    for (int i = 0; i < 32; i++) exp_tx.push_back(f[255-8*i -: 8]);
  endtask

  task automatic pulse_start(input logic [127:0] pt, input logic [127:0] key);
    @(negedge clk);
    plaintext_in = pt;
    key_in       = key;
    start_in     = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int b;
    b = 0;
    while (tx_pulses < n && b < 6000) begin
      @(negedge clk);
      b++;
    end
    flag("wait_tx_pulses", tx_pulses >= n, tx_pulses);
  endtask

  task automatic send_rx(input logic [127:0] ct, input int n, input bit start_mid);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      rx_byte_in  = ct[127-8*j -: 8];
      rx_dv_in    = 1'b1;
      last_rx_cyc = cyc;
      @(negedge clk);
      rx_dv_in = 1'b0;
      repeat (2) @(negedge clk);
      if (start_mid && j == 4) pulse_start(~PT, ~KEY);
    end
  endtask

  task automatic wait_ev(input int budget);
    int b;
    b = 0;
    while (exp_ev.size() != 0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    flag("completion_seen", exp_ev.size() == 0, exp_ev.size());
  endtask

  task automatic run_frame(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct,
                           input int nrx, input bit tmo, input bit inj_start,
                           input bit hold5, input bit inj_rx);
    int n0;
    ev_t ev;
    tx_pulses = 0;
    push_tx(pt, key);
    ev.is_tmo = tmo;
    ev.val    = ct;
    exp_ev.push_back(ev);
    pulse_start(pt, key);
    check("busy_after_start", {127'h0, busy_out}, 128'h1);
    if (inj_start) begin
      wait_tx(3);
      pulse_start(~pt, ~key);
    end
    if (inj_rx) begin
      wait_tx(2);
      @(negedge clk);
      rx_byte_in = 8'hAA;
      rx_dv_in   = 1'b1;
      @(negedge clk);
      rx_dv_in = 1'b0;
    end
    if (hold5) begin
      wait_tx(4);
      hold_active = 1'b1;
      n0 = tx_pulses;
      repeat (500) @(negedge clk);
      flag("no_dv_while_tx_active", tx_pulses == n0, tx_pulses);
      hold_active = 1'b0;
    end
    wait_tx(32);
    repeat (10) @(negedge clk);
    send_rx(ct, nrx, inj_start);
    wait_ev(tmo ? TMO + 60 : 30);
    flag("tx_pulse_total", tx_pulses == 32, tx_pulses);
    flag("tx_queue_drained", exp_tx.size() == 0, exp_tx.size());
    check("busy_low_after_frame", {127'h0, busy_out}, 128'h0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    #2;
    check("reset_busy", {127'h0, busy_out}, 128'h0);
    check("reset_result", result_out, 128'h0);
    check("reset_done_tmo_dv", {125'h0, done_out, timeout_out, tx_dv_out}, 128'h0);
    check("reset_tx_byte", {120'h0, tx_byte_out}, 128'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // T1: FIPS-197 frame
    run_frame(PT, KEY, CT, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    // T2: partial reply then silence
    run_frame(PT, KEY, 128'h0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    check("result_held_after_timeout", result_out, CT);
    // T3: stray start pulses during SEND and RECV
    run_frame(128'hfedcba98765432100123456789abcdef, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0,
              128'h1234567890abcdef1122334455667788, 16, 1'b0, 1'b1, 1'b0, 1'b0);
    // T4: transmitter busy for 500 cycles before byte 5
    run_frame(PT, KEY, CT, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    // T5: echo byte during SEND
    run_frame(PT, KEY, CT, 16, 1'b0, 1'b0, 1'b0, 1'b1);

    // T6: reset in the middle of the request
    tx_pulses = 0;
    push_tx(PT, KEY);
    pulse_start(PT, KEY);
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!(tx_dv_out && tx_pulses >= 20) && b < 3000);
    flag("reached_byte_20", b < 3000, tx_pulses);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_tx_dv", {127'h0, tx_dv_out}, 128'h0);
    check("midreset_tx_byte", {120'h0, tx_byte_out}, 128'h0);
    check("midreset_busy", {127'h0, busy_out}, 128'h0);
    check("midreset_result", result_out, 128'h0);
    exp_tx.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_frame(PT, KEY, CT, 16, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
